axi4lite_master_bridge: RTL
===========================

Name: axi4lite_master_bridge

Overview:
- Single-outstanding AXI4-Lite initiator (manager).
- Converts a simple local request/ack bus into AXI4-Lite write (AW/W/B) or read (AR/R) transactions.
- Drives the generated register-bank slaves from local controllers and test benches.
- Exactly one transaction is in flight at a time; results return on a one-cycle ack pulse.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr_i and awaddr/araddr (min 3)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
req_i  in  1  request strobe; sampled only in IDLE
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] forwarded unchanged
req_wdata_i  in  32  write data
req_wstrb_i  in  4  write byte strobes
busy_o  out  1  1 whenever state != IDLE
ack_o  out  1  one-cycle completion pulse
err_o  out  1  valid with ack_o; 1 if response code != 2'b00
rdata_o  out  32  read data, valid with ack_o for reads
awvalid  out  1
awready  in  1
awaddr  out  ADDR_WIDTH
awprot  out  3  constant 3'b000
wvalid  out  1
wready  in  1
wdata  out  32
wstrb  out  4
bvalid  in  1
bready  out  1
bresp  in  2
arvalid  out  1
arready  in  1
araddr  out  ADDR_WIDTH
arprot  out  3  constant 3'b000
rvalid  in  1
rready  out  1
rdata  in  32
rresp  in  2

Behaviour:
- Reset (areset=1 at a clock edge): state=IDLE; all valid/ready outputs, busy_o, ack_o and err_o = 0; rdata_o = 0; awaddr/araddr/wdata = 0; wstrb = 4'b0000.
  - Reset mid-transaction aborts immediately; no ack is produced.
- States and transitions:
  - IDLE:
    - req_i=1 latches we/addr/wdata/wstrb into the AXI output registers.
    - Write: next state WADDR, awvalid=wvalid=1 from the next cycle.
    - Read: next state RADDR, arvalid=1 from the next cycle.
  - WADDR:
    - awvalid clears on the cycle after awvalid&awready; wvalid clears on the cycle after wvalid&wready; the two are independent, in either order or simultaneous.
    - When both handshakes are done (including the same cycle), next state WRESP with bready=1.
    - bready is never 1 before both handshakes have completed.
  - WRESP: on bvalid&bready: bready=0; ack_o=1 and err_o=(bresp!=2'b00) in the following cycle (state DONE).
  - RADDR: on arvalid&arready: arvalid=0, rready=1, next state RRESP.
  - RRESP: on rvalid&rready: rready=0; capture rdata into rdata_o and set err_o=(rresp!=2'b00); ack_o=1 in the following cycle (state DONE).
  - DONE: one cycle; ack_o=1, busy_o=1; returns to IDLE.
    - ack_o and err_o return to 0 afterwards; rdata_o holds until the next read completes.
- Protocol rules:
  - valid outputs never deassert before their handshake.
  - AXI address/data outputs are stable while valid is asserted.
  - No combinational path from any AXI input to any AXI output.
- req_i while busy_o=1 is ignored (not queued).
  - The earliest a new request can be accepted is the IDLE cycle after DONE.
- Minimum latency with zero-wait slave (ready already high, response the cycle after): req_i at cycle 0 → ack_o at cycle 4 for both reads and writes.
- Write completion leaves rdata_o unchanged.

Test Plan:
- Write with always-ready slave: req_we_i=1, addr=0x14, wdata=0xDEADBEEF, wstrb=4'hF.
  → awaddr=0x14 and wdata=0xDEADBEEF presented together; one ack_o pulse; err_o=0; busy_o low the cycle after ack.
- Read of slave register: addr=0x10, slave returns rdata=0x0000000B, rresp=00.
  → rdata_o=0x0000000B with ack_o; err_o=0.
- Skewed write handshakes: wready high at cycle 1, awready delayed to cycle 5; then repeat reversed.
  → bready rises only after the later handshake; exactly one ack in each case.
- Error response: bresp=2'b10 on a write, then rresp=2'b11 on a read with rdata=0x12345678.
  → err_o=1 on each ack; rdata_o=0x12345678.
- Back-pressure and ignored request:
  - arready held low for 10 cycles; req_i pulsed during that wait → arvalid and araddr stable throughout; the second request is not executed.
- Reset mid-write: assert areset while in WRESP.
  → all valids, bready, busy_o and ack_o are 0 next cycle; no ack is ever emitted for that write.

Source files
------------

// File: rtl/axi4lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_master_bridge
// Brief    : Single-outstanding AXI4-Lite manager. Turns a local req/ack
//            strobe interface into one AXI4-Lite write (AW/W/B) or read
//            (AR/R) transaction at a time; completion is a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_master_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  // local request side
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  // AXI4-Lite write address channel
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  // write data channel
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  // write response channel
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  // read address channel
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  // read data channel
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state;

  // A channel counts as finished once its valid has dropped or it is
  // handshaking right now; this lets AW and W complete in any order.
  logic aw_done;
  logic w_done;

  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  assign busy_o = (state != S_IDLE);
  assign awprot = 3'b000;
  assign arprot = 3'b000;

  // Transaction sequencer; every AXI output is a register, so no AXI input
  // reaches an AXI output combinationally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= S_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'h0;
      awaddr  <= '0;
      araddr  <= '0;
      wdata   <= 32'h0;
      wstrb   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            if (req_we_i) begin
              awaddr  <= req_addr_i;
              wdata   <= req_wdata_i;
              wstrb   <= req_wstrb_i;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WADDR;
            end else begin
              araddr  <= req_addr_i;
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            ack_o  <= 1'b1;
            err_o  <= (bresp != 2'b00);
            state  <= S_DONE;
          end
        end
        S_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (rvalid) begin
            rready  <= 1'b0;
            rdata_o <= rdata;
            err_o   <= (rresp != 2'b00);
            ack_o   <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          // ack/err live for exactly this one cycle; rdata_o is held
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
